// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared types and sizing for the fifo_rd_drain read-side consumer.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_e;

    localparam int SKID_DEPTH    = 2;
    localparam int OCC_W         = $clog2(SKID_DEPTH + 1);
    localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: two-entry in-order buffer between the FIFO read port and the
// output stream; the head entry is what downstream sees.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int DSIZE = 8
) (
    input  logic             rclk,
    input  logic             rst,
    input  logic             push,
    input  logic [DSIZE-1:0] push_data,
    input  logic             pop,
    output logic [OCC_W-1:0] occ,
    output logic [DSIZE-1:0] head_data
);

    logic [DSIZE-1:0] head_q, head_d;
    logic [DSIZE-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [OCC_W-1:0] wr_idx;

    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        head_d = head_q;
        tail_d = tail_q;
        wr_idx = occ_q - OCC_W'(pop);
        occ_d  = occ_q + OCC_W'(push) - OCC_W'(pop);

        if (pop) begin
            head_d = tail_q;
        end
        // The new word lands behind whatever survives this cycle's pop.
        if (push) begin
            if (wr_idx == '0) begin
                head_d = push_data;
            end else begin
                tail_d = push_data;
            end
        end
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            // NOTE: the data entries are reset too, because head_q is m_data and must read 0 out of reset.
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign occ       = occ_q;
    assign head_data = head_q;

endmodule

// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: pops an asynfifo read port into a 2-entry skid and streams it
// out on valid/ready. Optional statistics are built with FIFO_RD_STATS_EN.
module fifo_rd_drain
    import fifo_rd_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             rclk,
    input  logic             rst,
    input  logic             en,
    input  logic             empty,
    input  logic [DSIZE-1:0] rdata,
    input  logic             underflow,
    output logic             ren,
    output logic             m_valid,
    output logic [DSIZE-1:0] m_data,
    input  logic             m_ready,
    output logic             busy,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] stall_count,
    output logic             err_underflow
);

    state_e           state_q, state_d;
    logic             infl_q, infl_d;
    logic [OCC_W-1:0] occ;
    logic [DSIZE-1:0] head_data;
    logic             pop;
    logic [2:0]       credit;

    fifo_rd_skid #(
        .DSIZE (DSIZE)
    ) u_skid (
        .rclk      (rclk),
        .rst       (rst),
        .push      (infl_q),
        .push_data (rdata),
        .pop       (pop),
        .occ       (occ),
        .head_data (head_data)
    );

    assign m_valid = (occ != '0);
    assign m_data  = head_data;
    assign pop     = m_valid && m_ready;
    // occ + infl never exceeds SKID_DEPTH, so credit cannot go negative.
    assign credit  = 3'(SKID_DEPTH) + 3'(pop) - 3'(occ) - 3'(infl_q);
    assign ren     = (state_q == RUN) && !empty && (credit != 3'd0);
    assign busy    = (state_q != IDLE) || m_valid;

    always_comb begin
        state_d = state_q;
        infl_d  = ren;
        unique case (state_q)
            IDLE: if (en) state_d = RUN;
            RUN:  if (!en) state_d = infl_q ? STOP : IDLE;
            // No reads are issued here, so infl is clear after exactly one cycle.
            STOP: state_d = en ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rclk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            infl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            infl_q  <= infl_d;
        end
    end

`ifdef FIFO_RD_STATS_EN
    logic [CNT_W-1:0] rd_count_q, rd_count_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             err_underflow_q, err_underflow_d;

    always_comb begin
        rd_count_d      = rd_count_q + CNT_W'(ren);
        stall_count_d   = stall_count_q + CNT_W'(m_valid && !m_ready);
        err_underflow_d = err_underflow_q || underflow;
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            rd_count_q      <= '0;
            stall_count_q   <= '0;
            err_underflow_q <= 1'b0;
        end else begin
            rd_count_q      <= rd_count_d;
            stall_count_q   <= stall_count_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign rd_count      = rd_count_q;
    assign stall_count   = stall_count_q;
    assign err_underflow = err_underflow_q;
`else
    logic unused_underflow;
    assign unused_underflow = underflow;

    assign rd_count      = '0;
    assign stall_count   = '0;
    assign err_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb_fifo_rd_drain: directed stimulus against a behavioural FIFO model, with a
// scoreboard queue checked by an independent output monitor.
module tb_fifo_rd_drain;

    localparam int DSIZE = 8;
    localparam int CNT_W = 16;

`ifdef FIFO_RD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             rclk;
    logic             rst;
    logic             en;
    logic             empty = 1'b1;
    logic [DSIZE-1:0] rdata = '0;
    logic             underflow = 1'b0;
    logic             ren;
    logic             m_valid;
    logic [DSIZE-1:0] m_data;
    logic             m_ready;
    logic             busy;
    logic [CNT_W-1:0] rd_count;
    logic [CNT_W-1:0] stall_count;
    logic             err_underflow;

    fifo_rd_drain #(
        .DSIZE (DSIZE),
        .CNT_W (CNT_W)
    ) dut (
        .rclk          (rclk),
        .rst           (rst),
        .en            (en),
        .empty         (empty),
        .rdata         (rdata),
        .underflow     (underflow),
        .ren           (ren),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_ready       (m_ready),
        .busy          (busy),
        .rd_count      (rd_count),
        .stall_count   (stall_count),
        .err_underflow (err_underflow)
    );

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    int n_pass = 0;
    int n_total = 0;
    int viol_empty = 0;
    int viol_rst = 0;

    logic [DSIZE-1:0] fifo_q[$];
    logic [DSIZE-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // FIFO model: one-cycle read latency, registered empty flag.
    always @(posedge rclk) begin
        if (ren) begin
            if (fifo_q.size() > 0) rdata <= fifo_q.pop_front();
            else underflow <= 1'b1;
        end
        empty <= (fifo_q.size() == 0);
    end

    // Output monitor and scoreboard.
    always @(negedge rclk) begin
        if (ren && empty) viol_empty++;
        if (rst && ren) viol_rst++;
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_extra_word: got 0x%0h expected no word", m_data);
            end else begin
                check("sb_data", 32'(m_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic push_word(input logic [DSIZE-1:0] w, input bit expect_out);
        fifo_q.push_back(w);
        if (expect_out) exp_q.push_back(w);
    endtask

    task automatic load(input int n, input logic [DSIZE-1:0] base, input bit expect_out);
        for (int i = 0; i < n; i++) push_word(base + DSIZE'(i), expect_out);
    endtask

    task automatic pulse_reset();
        @(posedge rclk); #1 rst = 1'b1;
        @(posedge rclk); #1 rst = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge rclk);
            if (exp_q.size() == 0 && !m_valid && fifo_q.size() == 0) done = 1'b1;
        end
        check({name, "_drained"}, 32'(done), 32'd1);
        @(posedge rclk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_ren, first_mv;
        int ren_run, mv_run, max_ren, max_mv, ren_tot;
        int stall_seen, ren_stall, mv_cnt, ren_late, ren_cnt;
        logic busy3, busy5;

        rst = 1'b1; en = 1'b1; m_ready = 1'b1;

        // Test 1: reset with en high and three words waiting.
        @(posedge rclk); #1;
        push_word(8'h11, 1'b1);
        push_word(8'h22, 1'b1);
        push_word(8'h33, 1'b1);
        repeat (3) @(posedge rclk);
        @(negedge rclk);
        check("rst_ren", 32'(ren), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_count", 32'(rd_count), 32'd0);
        check("rst_stall_count", 32'(stall_count), 32'd0);
        check("rst_err_underflow", 32'(err_underflow), 32'd0);
        @(posedge rclk); #1 rst = 1'b0;
        first_ren = -1; first_mv = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge rclk);
            if (ren && first_ren < 0) first_ren = c;
            if (m_valid && first_mv < 0) first_mv = c;
        end
        check("t1_first_ren_cycle", 32'(first_ren), 32'd1);
        check("t1_first_valid_cycle", 32'(first_mv), 32'd3);
        wait_drain("t1", 50);

        // Test 2: eight words at full rate.
        pulse_reset();
        load(8, 8'h40, 1'b1);
        ren_run = 0; mv_run = 0; max_ren = 0; max_mv = 0; ren_tot = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge rclk);
            ren_run = ren ? ren_run + 1 : 0;
            mv_run  = m_valid ? mv_run + 1 : 0;
            if (ren) ren_tot++;
            if (ren_run > max_ren) max_ren = ren_run;
            if (mv_run > max_mv) max_mv = mv_run;
        end
        check("t2_ren_run", 32'(max_ren), 32'd8);
        check("t2_ren_total", 32'(ren_tot), 32'd8);
        check("t2_valid_run", 32'(max_mv), 32'd8);
        check("t2_rd_count", 32'(rd_count), STATS ? 32'd8 : 32'd0);
        wait_drain("t2", 50);

        // Test 3: downstream stalls for ten cycles mid-stream.
        pulse_reset();
        load(12, 8'h60, 1'b1);
        repeat (5) @(posedge rclk);
        #1 m_ready = 1'b0;
        stall_seen = 0; ren_stall = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge rclk);
            if (m_valid && !m_ready) stall_seen++;
            if (k > 0 && ren) ren_stall++;
        end
        @(posedge rclk); #1 m_ready = 1'b1;
        check("t3_stall_cycles_seen", 32'(stall_seen), 32'd10);
        check("t3_ren_during_stall", 32'(ren_stall), 32'd0);
        wait_drain("t3", 60);
        check("t3_stall_count", 32'(stall_count), STATS ? 32'd10 : 32'd0);
        check("t3_rd_count", 32'(rd_count), STATS ? 32'd12 : 32'd0);

        // Test 4: FIFO runs dry between two bursts.
        load(3, 8'h80, 1'b1);
        repeat (10) @(posedge rclk);
        #1 load(3, 8'h90, 1'b1);
        wait_drain("t4", 50);
        check("t4_err_underflow", 32'(err_underflow), 32'd0);

        // Test 5: en dropped with a read in flight.
        en = 1'b0;
        repeat (2) @(posedge rclk);
        #1 load(6, 8'hA0, 1'b0);
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'hA1);
        repeat (2) @(posedge rclk);
        #1 en = 1'b1;
        @(posedge rclk); #1;
        @(posedge rclk); #1 en = 1'b0;
        mv_cnt = 0; ren_late = 0; busy3 = 1'b0; busy5 = 1'b1;
        for (int c = 2; c < 10; c++) begin
            @(negedge rclk);
            if (m_valid) mv_cnt++;
            if (c >= 3 && ren) ren_late++;
            if (c == 3) busy3 = busy;
            if (c == 5) busy5 = busy;
        end
        check("t5_words_delivered", 32'(mv_cnt), 32'd2);
        check("t5_ren_after_stop", 32'(ren_late), 32'd0);
        check("t5_busy_in_stop", 32'(busy3), 32'd1);
        check("t5_busy_after_last_pop", 32'(busy5), 32'd0);
        check("t5_busy_idle", 32'(busy), 32'd0);
        check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

        // Test 6: reset with the skid full; stream resumes at the next FIFO word.
        @(posedge rclk); #1 m_ready = 1'b0; en = 1'b1;
        ren_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge rclk);
            if (ren) ren_cnt++;
        end
        check("t6_reads_to_fill", 32'(ren_cnt), 32'd2);
        check("t6_full_m_valid", 32'(m_valid), 32'd1);
        check("t6_full_head", 32'(m_data), 32'hA2);
        check("t6_full_ren", 32'(ren), 32'd0);
        @(posedge rclk); #1 rst = 1'b1;
        @(posedge rclk); #1 rst = 1'b0;
        @(negedge rclk);
        check("t6_post_rst_m_valid", 32'(m_valid), 32'd0);
        check("t6_post_rst_m_data", 32'(m_data), 32'd0);
        check("t6_post_rst_busy", 32'(busy), 32'd0);
        exp_q.push_back(8'hA4);
        exp_q.push_back(8'hA5);
        @(posedge rclk); #1 m_ready = 1'b1;
        wait_drain("t6", 50);
        check("t6_rd_count", 32'(rd_count), STATS ? 32'd2 : 32'd0);

        check("ren_while_empty", 32'(viol_empty), 32'd0);
        check("ren_during_reset", 32'(viol_rst), 32'd0);
        check("final_err_underflow", 32'(err_underflow), 32'd0);
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
